// File: rtl/nv_ram_fifo_pkg.sv
// Shared constants and pointer helper for the 80x72 RAM FIFO controller.
package nv_ram_fifo_pkg;

    localparam int DEPTH = 80;
    localparam int AW    = 7;
    localparam int DW    = 72;
    localparam int CW    = 7;

    // Pointers wrap at DEPTH-1, not at the natural 2^AW boundary.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

endpackage

// File: rtl/nv_ram_fifo_skid2.sv
// Two-entry in-order output buffer; registered head drives the read stream.
module nv_ram_fifo_skid2
    import nv_ram_fifo_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  logic [DW-1:0] in_pd,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [DW-1:0] out_pd,
    output logic [1:0]    occ
);

    logic [DW-1:0] head_q;
    logic [DW-1:0] tail_q;
    logic [1:0]    occ_q;
    logic          pop;

    assign out_vld = (occ_q != 2'd0);
    assign out_pd  = head_q;
    assign occ     = occ_q;
    assign pop     = out_vld & out_rdy;

    // The controller never captures into a full buffer, so no overflow path exists.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            case ({in_vld, pop})
                2'b10: begin
                    if (occ_q == 2'd0) head_q <= in_pd;
                    else               tail_q <= in_pd;
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        head_q <= in_pd;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= in_pd;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/nv_ram_fifo_ctrl_80x72.sv
// Valid/ready FIFO wrapper around the 80x72 pseudo-dual-port RAM.
// Optional build macro RAM_FIFO_BYPASS_EN lets pushes skip the RAM when its path is empty.
module nv_ram_fifo_ctrl_80x72
    import nv_ram_fifo_pkg::*;
(
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rst,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic          ram_we,
    output logic [AW-1:0] ram_wa,
    output logic [DW-1:0] ram_wd,
    output logic          ram_re,
    output logic [AW-1:0] ram_ra,
    input  logic [DW-1:0] ram_rd,
    output logic [CW-1:0] fifo_cnt
);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] ram_cnt;
    logic          inflight;
    logic          rdy_en;
    logic [1:0]    skid_occ;
    logic          push;
    logic          push_ram;
    logic          byp_push;
    logic          issue;
    logic          cap_vld;
    logic [DW-1:0] cap_pd;

    assign wr_prdy = rdy_en & (ram_cnt < CW'(DEPTH));
    assign push    = wr_pvld & wr_prdy;

`ifdef RAM_FIFO_BYPASS_EN
    // Safe for ordering: nothing older can be in the RAM or in flight.
    assign byp_push = push & (ram_cnt == '0) & ~inflight & (skid_occ != 2'd2);
`else
    assign byp_push = 1'b0;
`endif

    assign push_ram = push & ~byp_push;

    // A word written this cycle is not counted yet, so reads never hit the write address.
    assign issue = (ram_cnt != '0) &
                   ((skid_occ == 2'd0) | ((skid_occ == 2'd1) & ~inflight));

    assign ram_we = push_ram;
    assign ram_wa = wptr;
    assign ram_wd = push_ram ? wr_pd : '0;
    assign ram_re = issue;
    assign ram_ra = rptr;

    assign cap_vld = inflight | byp_push;
    assign cap_pd  = inflight ? ram_rd : wr_pd;

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            rdy_en   <= 1'b0;
        end else begin
            rdy_en   <= 1'b1;
            inflight <= issue;
            if (push_ram) wptr <= ptr_inc(wptr);
            if (issue)    rptr <= ptr_inc(rptr);
            case ({push_ram, issue})
                2'b10:   ram_cnt <= ram_cnt + CW'(1);
                2'b01:   ram_cnt <= ram_cnt - CW'(1);
                default: ;
            endcase
        end
    end

    nv_ram_fifo_skid2 u_skid (
        .clk     (nvdla_core_clk),
        .rst     (nvdla_core_rst),
        .in_vld  (cap_vld),
        .in_pd   (cap_pd),
        .out_vld (rd_pvld),
        .out_rdy (rd_prdy),
        .out_pd  (rd_pd),
        .occ     (skid_occ)
    );

    assign fifo_cnt = ram_cnt + CW'(inflight) + CW'(skid_occ);

endmodule

// File: tb/tb_nv_ram_fifo_ctrl_80x72.sv
// Self-checking bench for nv_ram_fifo_ctrl_80x72 with a queue-based reference model.
`timescale 1ns/1ps
module tb_nv_ram_fifo_ctrl_80x72;
    import nv_ram_fifo_pkg::*;

`ifdef RAM_FIFO_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 3;
`endif

    logic          nvdla_core_clk = 1'b0;
    logic          nvdla_core_rst = 1'b1;
    logic          wr_pvld = 1'b0;
    logic          wr_prdy;
    logic [DW-1:0] wr_pd = '0;
    logic          rd_pvld;
    logic          rd_prdy = 1'b0;
    logic [DW-1:0] rd_pd;
    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic [DW-1:0] ram_wd;
    logic          ram_re;
    logic [AW-1:0] ram_ra;
    logic [DW-1:0] ram_rd;
    logic [CW-1:0] fifo_cnt;

    logic [DW-1:0] mem [128];
    logic [DW-1:0] ram_rd_q;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model: RAM contents as a queue, one in-flight slot, skid as a queue
    logic [DW-1:0] ramq[$];
    logic [DW-1:0] skidq[$];
    logic [DW-1:0] sent[$];
    logic [DW-1:0] dut_got[$];
    bit            infl;
    logic [DW-1:0] infl_d;
    int            wptr_m, rptr_m;
    bit            rdy_ok;
    bit            e_prdy, e_push, e_byp, e_we, e_re, e_pvld;
    int            e_wa, e_ra, e_cnt;
    logic [DW-1:0] e_pd;

    nv_ram_fifo_ctrl_80x72 dut (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rst (nvdla_core_rst),
        .wr_pvld        (wr_pvld),
        .wr_prdy        (wr_prdy),
        .wr_pd          (wr_pd),
        .rd_pvld        (rd_pvld),
        .rd_prdy        (rd_prdy),
        .rd_pd          (rd_pd),
        .ram_we         (ram_we),
        .ram_wa         (ram_wa),
        .ram_wd         (ram_wd),
        .ram_re         (ram_re),
        .ram_ra         (ram_ra),
        .ram_rd         (ram_rd),
        .fifo_cnt       (fifo_cnt)
    );

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    always @(posedge nvdla_core_clk) begin
        if (ram_we) mem[ram_wa] <= ram_wd;
        if (ram_re) ram_rd_q <= mem[ram_ra];
    end
    assign ram_rd = ram_rd_q;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] rnd_pd();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    task automatic model_clear();
        ramq.delete();
        skidq.delete();
        infl   = 1'b0;
        infl_d = '0;
        wptr_m = 0;
        rptr_m = 0;
        rdy_ok = 1'b0;
    endtask

    task automatic eval();
        e_prdy = rdy_ok && (ramq.size() < DEPTH);
        e_push = wr_pvld && e_prdy;
`ifdef RAM_FIFO_BYPASS_EN
        e_byp = e_push && (ramq.size() == 0) && !infl && (skidq.size() < 2);
`else
        e_byp = 1'b0;
`endif
        e_we   = e_push && !e_byp;
        e_re   = (ramq.size() > 0) && ((skidq.size() + int'(infl)) < 2);
        e_wa   = wptr_m;
        e_ra   = rptr_m;
        e_pvld = skidq.size() > 0;
        e_pd   = e_pvld ? skidq[0] : '0;
        e_cnt  = ramq.size() + int'(infl) + skidq.size();
    endtask

    // advance one clock; model follows the architectural rules, DUT pops are recorded
    task automatic step();
        bit            pop_m;
        logic [DW-1:0] pd_in;
        pop_m = e_pvld && rd_prdy;
        pd_in = wr_pd;
        if (rd_pvld && rd_prdy) dut_got.push_back(rd_pd);
        if (e_push) sent.push_back(wr_pd);
        @(posedge nvdla_core_clk);
        if (nvdla_core_rst) begin
            model_clear();
        end else begin
            if (pop_m) skidq.delete(0);
            if (infl)  skidq.push_back(infl_d);
            if (e_byp) skidq.push_back(pd_in);
            infl = e_re;
            if (e_re) begin
                infl_d = ramq.pop_front();
                rptr_m = (rptr_m + 1) % DEPTH;
            end
            if (e_we) begin
                ramq.push_back(pd_in);
                wptr_m = (wptr_m + 1) % DEPTH;
            end
            rdy_ok = 1'b1;
        end
        #1;
    endtask

    task automatic drain(input int max_cycles, output bit done);
        done = 1'b0;
        wr_pvld = 1'b0;
        rd_prdy = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            #1; eval();
            if (dut_got.size() >= sent.size() && e_cnt == 0 && !rd_pvld) begin
                done = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        wr_pvld = 1'b1; wr_pd = rnd_pd(); rd_prdy = 1'b1;
        repeat (2) @(posedge nvdla_core_clk);
        #1;
        n_chk++; if (wr_prdy !== 1'b0)  begin n_fail++; $display("FAIL rst_wr_prdy got=%b exp=0", wr_prdy); end
        n_chk++; if (rd_pvld !== 1'b0)  begin n_fail++; $display("FAIL rst_rd_pvld got=%b exp=0", rd_pvld); end
        n_chk++; if (rd_pd !== '0)      begin n_fail++; $display("FAIL rst_rd_pd got=%h exp=0", rd_pd); end
        n_chk++; if (ram_we !== 1'b0)   begin n_fail++; $display("FAIL rst_ram_we got=%b exp=0", ram_we); end
        n_chk++; if (ram_re !== 1'b0)   begin n_fail++; $display("FAIL rst_ram_re got=%b exp=0", ram_re); end
        n_chk++; if (ram_wa !== '0)     begin n_fail++; $display("FAIL rst_ram_wa got=%0d exp=0", ram_wa); end
        n_chk++; if (ram_ra !== '0)     begin n_fail++; $display("FAIL rst_ram_ra got=%0d exp=0", ram_ra); end
        n_chk++; if (ram_wd !== '0)     begin n_fail++; $display("FAIL rst_ram_wd got=%h exp=0", ram_wd); end
        n_chk++; if (fifo_cnt !== '0)   begin n_fail++; $display("FAIL rst_fifo_cnt got=%0d exp=0", fifo_cnt); end
        nvdla_core_rst = 1'b0;
        model_clear();
        wr_pvld = 1'b0;
        #1; eval();
        step();
        #1; eval();
        n_chk++; if (wr_prdy !== 1'b1)  begin n_fail++; $display("FAIL rst_release_wr_prdy got=%b exp=1", wr_prdy); end
    endtask

    task automatic test_single();
        int lat = -1;
        bit done;
        sent.delete(); dut_got.delete();
        rd_prdy = 1'b1;
        for (int c = 0; c < 8; c++) begin
            wr_pvld = (c == 0);
            wr_pd   = (c == 0) ? 72'h0A5 : rnd_pd();
            #1; eval();
            n_chk++; if (ram_we !== e_we) begin n_fail++; $display("FAIL single_we c=%0d got=%b exp=%b", c, ram_we, e_we); end
            if (e_we) begin
                n_chk++; if (ram_wa !== AW'(e_wa)) begin n_fail++; $display("FAIL single_wa got=%0d exp=%0d", ram_wa, e_wa); end
                n_chk++; if (ram_wd !== 72'h0A5)  begin n_fail++; $display("FAIL single_wd got=%h exp=0a5", ram_wd); end
            end
            n_chk++; if (ram_re !== e_re) begin n_fail++; $display("FAIL single_re c=%0d got=%b exp=%b", c, ram_re, e_re); end
            if (e_re) begin
                n_chk++; if (ram_ra !== AW'(e_ra)) begin n_fail++; $display("FAIL single_ra got=%0d exp=%0d", ram_ra, e_ra); end
            end
            n_chk++; if (rd_pvld !== e_pvld) begin n_fail++; $display("FAIL single_pvld c=%0d got=%b exp=%b", c, rd_pvld, e_pvld); end
            if (e_pvld) begin
                n_chk++; if (rd_pd !== 72'h0A5) begin n_fail++; $display("FAIL single_pd got=%h exp=0a5", rd_pd); end
            end
            if (rd_pvld && lat < 0) lat = c;
            step();
        end
        n_chk++; if (lat != LAT) begin n_fail++; $display("FAIL single_latency got=%0d exp=%0d", lat, LAT); end
        drain(20, done);
    endtask

    task automatic test_fill_drain();
        int acc = 0;
        bit done;
        sent.delete(); dut_got.delete();
        rd_prdy = 1'b0;
        for (int c = 0; c < 100; c++) begin
            wr_pvld = 1'b1; wr_pd = rnd_pd();
            #1; eval();
            n_chk++; if (fifo_cnt !== CW'(e_cnt)) begin n_fail++; $display("FAIL fill_cnt c=%0d got=%0d exp=%0d", c, fifo_cnt, e_cnt); end
            n_chk++; if (ram_re !== e_re) begin n_fail++; $display("FAIL fill_re c=%0d got=%b exp=%b", c, ram_re, e_re); end
            if (wr_pvld && wr_prdy) acc++;
            step();
        end
        #1;
        n_chk++; if (acc != DEPTH + 2)              begin n_fail++; $display("FAIL fill_accepted got=%0d exp=%0d", acc, DEPTH + 2); end
        n_chk++; if (fifo_cnt !== CW'(DEPTH + 2))   begin n_fail++; $display("FAIL fill_full_cnt got=%0d exp=%0d", fifo_cnt, DEPTH + 2); end
        n_chk++; if (wr_prdy !== 1'b0)              begin n_fail++; $display("FAIL fill_wr_prdy got=%b exp=0", wr_prdy); end
        drain(400, done);
        n_chk++; if (!done) begin n_fail++; $display("FAIL fill_drain_timeout got=%0d exp=%0d", dut_got.size(), sent.size()); end
        n_chk++; if (dut_got.size() != DEPTH + 2) begin n_fail++; $display("FAIL fill_drain_count got=%0d exp=%0d", dut_got.size(), DEPTH + 2); end
        for (int i = 0; i < sent.size() && i < dut_got.size(); i++) begin
            n_chk++; if (dut_got[i] !== sent[i]) begin n_fail++; $display("FAIL fill_data i=%0d got=%h exp=%h", i, dut_got[i], sent[i]); end
        end
    endtask

    task automatic test_wrap();
        bit done;
        sent.delete(); dut_got.delete();
        rd_prdy = 1'b1;
        for (int c = 0; c < 200; c++) begin
            wr_pvld = 1'b1; wr_pd = rnd_pd();
            #1; eval();
            n_chk++; if (wr_prdy !== 1'b1) begin n_fail++; $display("FAIL wrap_bubble c=%0d got=%b exp=1", c, wr_prdy); end
            n_chk++; if (ram_re !== e_re)  begin n_fail++; $display("FAIL wrap_re c=%0d got=%b exp=%b", c, ram_re, e_re); end
            if (e_we) begin
                n_chk++; if (ram_wa !== AW'(e_wa)) begin n_fail++; $display("FAIL wrap_wa c=%0d got=%0d exp=%0d", c, ram_wa, e_wa); end
            end
            if (e_re) begin
                n_chk++; if (ram_ra !== AW'(e_ra)) begin n_fail++; $display("FAIL wrap_ra c=%0d got=%0d exp=%0d", c, ram_ra, e_ra); end
            end
            step();
        end
        drain(400, done);
        n_chk++; if (!done) begin n_fail++; $display("FAIL wrap_drain_timeout got=%0d exp=%0d", dut_got.size(), sent.size()); end
        n_chk++; if (dut_got.size() != 200) begin n_fail++; $display("FAIL wrap_count got=%0d exp=200", dut_got.size()); end
        for (int i = 0; i < sent.size() && i < dut_got.size(); i++) begin
            n_chk++; if (dut_got[i] !== sent[i]) begin n_fail++; $display("FAIL wrap_data i=%0d got=%h exp=%h", i, dut_got[i], sent[i]); end
        end
    endtask

    task automatic test_simul_push_issue();
        bit done;
        sent.delete(); dut_got.delete();
        rd_prdy = 1'b0;
        for (int c = 0; c < DEPTH + 1; c++) begin
            wr_pvld = 1'b1; wr_pd = rnd_pd();
            #1; eval(); step();
        end
        wr_pvld = 1'b0;
        repeat (4) begin #1; eval(); step(); end
        rd_prdy = 1'b1;
        #1; eval(); step();
        rd_prdy = 1'b0; wr_pvld = 1'b1; wr_pd = rnd_pd();
        #1; eval();
        n_chk++; if (ram_re !== 1'b1)  begin n_fail++; $display("FAIL simul_re got=%b exp=1", ram_re); end
        n_chk++; if (ram_we !== 1'b1)  begin n_fail++; $display("FAIL simul_we got=%b exp=1", ram_we); end
        n_chk++; if (wr_prdy !== 1'b1) begin n_fail++; $display("FAIL simul_prdy got=%b exp=1", wr_prdy); end
        step();
        wr_pvld = 1'b0;
        #1; eval();
        n_chk++; if (fifo_cnt !== CW'(DEPTH + 1)) begin n_fail++; $display("FAIL simul_cnt got=%0d exp=%0d", fifo_cnt, DEPTH + 1); end
        n_chk++; if (wr_prdy !== 1'b1) begin n_fail++; $display("FAIL simul_prdy_after got=%b exp=1", wr_prdy); end
        n_chk++; if (ram_re !== 1'b0)  begin n_fail++; $display("FAIL simul_no_issue got=%b exp=0", ram_re); end
        drain(400, done);
        n_chk++; if (!done) begin n_fail++; $display("FAIL simul_drain_timeout got=%0d exp=%0d", dut_got.size(), sent.size()); end
        for (int i = 0; i < sent.size() && i < dut_got.size(); i++) begin
            n_chk++; if (dut_got[i] !== sent[i]) begin n_fail++; $display("FAIL simul_data i=%0d got=%h exp=%h", i, dut_got[i], sent[i]); end
        end
    endtask

    task automatic test_random();
        bit done;
        sent.delete(); dut_got.delete();
        for (int c = 0; c < 500; c++) begin
            wr_pvld = ($urandom_range(0, 3) != 0);
            wr_pd   = rnd_pd();
            rd_prdy = $urandom_range(0, 1);
            #1; eval();
            n_chk++; if (ram_re !== e_re) begin n_fail++; $display("FAIL rand_re c=%0d got=%b exp=%b", c, ram_re, e_re); end
            n_chk++; if (fifo_cnt !== CW'(e_cnt)) begin n_fail++; $display("FAIL rand_cnt c=%0d got=%0d exp=%0d", c, fifo_cnt, e_cnt); end
            n_chk++; if (rd_pvld !== e_pvld) begin n_fail++; $display("FAIL rand_pvld c=%0d got=%b exp=%b", c, rd_pvld, e_pvld); end
            if (e_pvld) begin
                n_chk++; if (rd_pd !== e_pd) begin n_fail++; $display("FAIL rand_pd c=%0d got=%h exp=%h", c, rd_pd, e_pd); end
            end
            step();
        end
        drain(400, done);
        n_chk++; if (!done) begin n_fail++; $display("FAIL rand_drain_timeout got=%0d exp=%0d", dut_got.size(), sent.size()); end
        n_chk++; if (dut_got.size() != sent.size()) begin n_fail++; $display("FAIL rand_count got=%0d exp=%0d", dut_got.size(), sent.size()); end
        for (int i = 0; i < sent.size() && i < dut_got.size(); i++) begin
            n_chk++; if (dut_got[i] !== sent[i]) begin n_fail++; $display("FAIL rand_data i=%0d got=%h exp=%h", i, dut_got[i], sent[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int lat = -1;
        rd_prdy = 1'b0;
        for (int c = 0; c < 10; c++) begin
            wr_pvld = 1'b1; wr_pd = rnd_pd();
            #1; eval(); step();
        end
        wr_pvld = 1'b0;
        repeat (3) begin #1; eval(); step(); end
        n_chk++; if (fifo_cnt !== CW'(10)) begin n_fail++; $display("FAIL mid_held got=%0d exp=10", fifo_cnt); end
        wr_pvld = 1'b1; wr_pd = rnd_pd();
        nvdla_core_rst = 1'b1;
        #1;
        n_chk++; if (wr_prdy !== 1'b0) begin n_fail++; $display("FAIL mid_wr_prdy got=%b exp=0", wr_prdy); end
        n_chk++; if (rd_pvld !== 1'b0) begin n_fail++; $display("FAIL mid_rd_pvld got=%b exp=0", rd_pvld); end
        n_chk++; if (rd_pd !== '0)     begin n_fail++; $display("FAIL mid_rd_pd got=%h exp=0", rd_pd); end
        n_chk++; if (fifo_cnt !== '0)  begin n_fail++; $display("FAIL mid_fifo_cnt got=%0d exp=0", fifo_cnt); end
        n_chk++; if (ram_we !== 1'b0)  begin n_fail++; $display("FAIL mid_ram_we got=%b exp=0", ram_we); end
        n_chk++; if (ram_re !== 1'b0)  begin n_fail++; $display("FAIL mid_ram_re got=%b exp=0", ram_re); end
        n_chk++; if (ram_ra !== '0)    begin n_fail++; $display("FAIL mid_ram_ra got=%0d exp=0", ram_ra); end
        model_clear();
        sent.delete(); dut_got.delete();
        wr_pvld = 1'b0;
        eval(); step();
        nvdla_core_rst = 1'b0;
        #1; eval(); step();
        rd_prdy = 1'b1;
        for (int c = 0; c < 8; c++) begin
            wr_pvld = (c == 0);
            wr_pd   = (c == 0) ? 72'h123 : rnd_pd();
            #1; eval();
            n_chk++; if (ram_we !== e_we) begin n_fail++; $display("FAIL mid_post_we c=%0d got=%b exp=%b", c, ram_we, e_we); end
            if (e_we) begin
                n_chk++; if (ram_wa !== '0) begin n_fail++; $display("FAIL mid_post_wa got=%0d exp=0", ram_wa); end
            end
            if (rd_pvld && lat < 0) lat = c;
            step();
        end
        n_chk++; if (lat != LAT) begin n_fail++; $display("FAIL mid_post_latency got=%0d exp=%0d", lat, LAT); end
        n_chk++; if (dut_got.size() != 1) begin n_fail++; $display("FAIL mid_post_count got=%0d exp=1", dut_got.size()); end
        if (dut_got.size() > 0) begin
            n_chk++; if (dut_got[0] !== 72'h123) begin n_fail++; $display("FAIL mid_post_data got=%h exp=123", dut_got[0]); end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single();
        test_fill_drain();
        test_wrap();
        test_simul_push_issue();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
